// File: rtl/pe_bs_fir.sv
// pe_bs_fir: K-tap FIR processing element with power-of-two weights. It uses one barrel
// shift and one saturating add per cycle, returns the result on a ready/valid
// handshake and keeps a sticky overflow flag.
module pe_bs_fir #(
  parameter int  DATA_W  = 8,
  parameter int  K       = 5,
  parameter int  SHIFT_W = 3,
  parameter int  ACC_W   = 20,
  localparam int IDX_W   = (K > 1) ? $clog2(K) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               wld_en,
  input  logic [IDX_W-1:0]   wld_idx,
  input  logic [SHIFT_W-1:0] wld_shift,
  input  logic               wld_neg,
  input  logic               wld_zero,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ACC_W-1:0]   out_data,
  output logic               sat_flag
);

  localparam int                      FILL_W  = $clog2(K + 1);
  localparam logic [IDX_W:0]          K_IDX   = (IDX_W + 1)'(K);
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    OUT  = 2'd2
  } state_t;

  state_t                  state_reg, state_next;
  logic [FILL_W-1:0]       fill_reg, fill_next, fill_inc;
  logic [IDX_W-1:0]        k_reg, k_next;
  logic signed [ACC_W-1:0] acc_reg, acc_next;
  logic signed [ACC_W-1:0] out_data_reg, out_data_next;
  logic                    sat_reg, sat_next;

  // Read views of the per-tap registers held in the generate blocks below.
  logic signed [DATA_W-1:0] win     [K];
  logic [SHIFT_W-1:0]       w_shift [K];
  logic                     w_neg   [K];
  logic                     w_zero  [K];

  logic accept;
  logic wld_ok;

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == OUT);
  assign out_data  = out_data_reg;
  assign sat_flag  = sat_reg;
  assign accept    = in_valid & in_ready;
  assign wld_ok    = wld_en & in_ready & ~flush & ({1'b0, wld_idx} < K_IDX);

  genvar gi;
  generate
    for (gi = 0; gi < K; gi++) begin : g_tap
      logic signed [DATA_W-1:0] win_reg;
      logic signed [DATA_W-1:0] win_in;
      logic [SHIFT_W-1:0]       shift_reg;
      logic                     neg_reg;
      logic                     zero_reg;

      if (gi == 0) begin : g_head
        assign win_in = in_data;
      end else begin : g_chain
        assign win_in = win[gi-1];
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          win_reg <= '0;
        end else if (flush) begin
          win_reg <= '0;
        end else if (accept) begin
          win_reg <= win_in;
        end
      end

      // Weights survive flush; only reset returns them to "zero tap".
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          shift_reg <= '0;
          neg_reg   <= 1'b0;
          zero_reg  <= 1'b1;
        end else if (wld_ok && (wld_idx == IDX_W'(gi))) begin
          shift_reg <= wld_shift;
          neg_reg   <= wld_neg;
          zero_reg  <= wld_zero;
        end
      end

      assign win[gi]     = win_reg;
      assign w_shift[gi] = shift_reg;
      assign w_neg[gi]   = neg_reg;
      assign w_zero[gi]  = zero_reg;
    end
  endgenerate

  // One tap per cycle: sign-extend, barrel shift, optional negate, saturating add.
  logic signed [DATA_W-1:0] tap_x;
  logic signed [ACC_W-1:0]  tap_ext;
  logic signed [ACC_W-1:0]  tap_shl;
  logic signed [ACC_W-1:0]  term;
  logic signed [ACC_W:0]    sum_wide;
  logic signed [ACC_W-1:0]  acc_sat;
  logic                     sat_hit;

  always_comb begin
    tap_x    = win[k_reg];
    tap_ext  = {{(ACC_W-DATA_W){tap_x[DATA_W-1]}}, tap_x};
    tap_shl  = tap_ext << w_shift[k_reg];
    term     = '0;
    if (!w_zero[k_reg]) begin
      term = w_neg[k_reg] ? -tap_shl : tap_shl;
    end
    sum_wide = {acc_reg[ACC_W-1], acc_reg} + {term[ACC_W-1], term};
    sat_hit  = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];
    acc_sat  = sum_wide[ACC_W-1:0];
    if (sat_hit) begin
      acc_sat = sum_wide[ACC_W] ? ACC_MIN : ACC_MAX;
    end
  end

  assign fill_inc = (fill_reg == FILL_W'(K)) ? fill_reg : fill_reg + FILL_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      fill_reg     <= '0;
      k_reg        <= '0;
      acc_reg      <= '0;
      out_data_reg <= '0;
      sat_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      fill_reg     <= fill_next;
      k_reg        <= k_next;
      acc_reg      <= acc_next;
      out_data_reg <= out_data_next;
      sat_reg      <= sat_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    fill_next     = fill_reg;
    k_next        = k_reg;
    acc_next      = acc_reg;
    out_data_next = out_data_reg;
    sat_next      = sat_reg;

    if (flush) begin
      // out_data deliberately keeps the last delivered result.
      state_next = IDLE;
      fill_next  = '0;
      k_next     = '0;
      acc_next   = '0;
      sat_next   = 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            fill_next = fill_inc;
            if (fill_inc == FILL_W'(K)) begin
              state_next = ACC;
              acc_next   = '0;
              k_next     = '0;
            end
          end
        end
        ACC: begin
          acc_next = acc_sat;
          k_next   = k_reg + IDX_W'(1);
          if (sat_hit) begin
            sat_next = 1'b1;
          end
          if (k_reg == IDX_W'(K - 1)) begin
            out_data_next = acc_sat;
            k_next        = '0;
            state_next    = OUT;
          end
        end
        OUT: begin
          if (out_ready) begin
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_bs_fir.sv
// tb_pe_bs_fir: drives two pe_bs_fir instances (20-bit and 16-bit accumulators) in
// lockstep and checks their results against an arithmetic FIR model through scoreboard queues.
module tb_pe_bs_fir;
  localparam int K = 5;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        wld_en;
  logic [2:0]  wld_idx;
  logic [2:0]  wld_shift;
  logic        wld_neg;
  logic        wld_zero;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        out_ready;
  logic        in_ready_a, out_valid_a, sat_a;
  logic [19:0] out_data_a;
  logic        in_ready_b, out_valid_b, sat_b;
  logic [15:0] out_data_b;
  logic        rand_ready;

  int errors = 0;
  int checks = 0;

  typedef struct {
    longint data;
    bit     sat;
  } exp_t;
  exp_t qa[$];
  exp_t qb[$];

  int m_win   [K];
  int m_shift [K];
  bit m_neg   [K];
  bit m_zero  [K];
  int m_fill;
  bit m_sticky_a, m_sticky_b;

  pe_bs_fir #(.DATA_W(8), .K(K), .SHIFT_W(3), .ACC_W(20)) dut_a (
    .clk(clk), .rst_n(rst_n), .flush(flush), .wld_en(wld_en), .wld_idx(wld_idx),
    .wld_shift(wld_shift), .wld_neg(wld_neg), .wld_zero(wld_zero),
    .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a),
    .sat_flag(sat_a)
  );

  pe_bs_fir #(.DATA_W(8), .K(K), .SHIFT_W(3), .ACC_W(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .flush(flush), .wld_en(wld_en), .wld_idx(wld_idx),
    .wld_shift(wld_shift), .wld_neg(wld_neg), .wld_zero(wld_zero),
    .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b),
    .sat_flag(sat_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // y = sum of w[k]*x[n-k], clamped to the accumulator range after every tap.
  function automatic longint ref_fir(input int accw, inout bit sticky);
    longint hi, lo, acc, term;
    hi  = (longint'(1) <<< (accw - 1)) - 1;
    lo  = -hi - 1;
    acc = 0;
    for (int k = 0; k < K; k++) begin
      term = m_zero[k] ? 0 : longint'(m_win[k]) * (longint'(1) <<< m_shift[k]);
      if (m_neg[k]) term = -term;
      acc = acc + term;
      if (acc > hi) begin
        acc = hi;
        sticky = 1'b1;
      end else if (acc < lo) begin
        acc = lo;
        sticky = 1'b1;
      end
    end
    return acc;
  endfunction

  function automatic void model_flush();
    for (int k = 0; k < K; k++) m_win[k] = 0;
    m_fill = 0;
    m_sticky_a = 1'b0;
    m_sticky_b = 1'b0;
    qa.delete();
    qb.delete();
  endfunction

  function automatic void model_reset();
    model_flush();
    for (int k = 0; k < K; k++) begin
      m_shift[k] = 0;
      m_neg[k]   = 1'b0;
      m_zero[k]  = 1'b1;
    end
  endfunction

  function automatic void model_weight(input int idx, input int sh, input bit ng, input bit zr);
    if (idx < K) begin
      m_shift[idx] = sh;
      m_neg[idx]   = ng;
      m_zero[idx]  = zr;
    end
  endfunction

  function automatic void model_accept(input int d);
    exp_t e;
    for (int k = K - 1; k > 0; k--) m_win[k] = m_win[k-1];
    m_win[0] = d;
    if (m_fill < K) m_fill++;
    if (m_fill == K) begin
      e.data = ref_fir(20, m_sticky_a);
      e.sat  = m_sticky_a;
      qa.push_back(e);
      e.data = ref_fir(16, m_sticky_b);
      e.sat  = m_sticky_b;
      qb.push_back(e);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!in_ready_a && n < 300) begin
      tick();
      n++;
    end
    check("in_ready_wait", longint'(in_ready_a), 1);
  endtask

  task automatic write_w(input int idx, input int sh, input bit ng, input bit zr);
    wait_idle();
    wld_en    = 1'b1;
    wld_idx   = 3'(idx);
    wld_shift = 3'(sh);
    wld_neg   = ng;
    wld_zero  = zr;
    tick();
    wld_en = 1'b0;
    model_weight(idx, sh, ng, zr);
  endtask

  task automatic send(input int d, input bit do_w, input int idx, input int sh,
                      input bit ng, input bit zr);
    wait_idle();
    if (!in_ready_a) return;
    in_valid = 1'b1;
    in_data  = 8'(d);
    if (do_w) begin
      wld_en    = 1'b1;
      wld_idx   = 3'(idx);
      wld_shift = 3'(sh);
      wld_neg   = ng;
      wld_zero  = zr;
    end
    tick();
    in_valid = 1'b0;
    wld_en   = 1'b0;
    if (do_w) model_weight(idx, sh, ng, zr);
    model_accept(d);
  endtask

  task automatic wait_valid(input string name, output int n);
    n = 0;
    while (!out_valid_a && n < 60) begin
      tick();
      n++;
    end
    check(name, longint'(out_valid_a), 1);
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    model_flush();
  endtask

  task automatic drain();
    int n = 0;
    while ((qa.size() != 0 || qb.size() != 0) && n < 500) begin
      tick();
      n++;
    end
    check("drain_a", qa.size(), 0);
    check("drain_b", qb.size(), 0);
  endtask

  // Scoreboard monitor: a transfer happens on the edge after a negedge where valid&ready.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (out_valid_a && out_ready) begin
        if (qa.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL out_a_unexpected: got result %0d, expected no result", $signed(out_data_a));
        end else begin
          e = qa.pop_front();
          check("out_data_a", longint'($signed(out_data_a)), e.data);
          check("sat_flag_a", longint'(sat_a), longint'(e.sat));
        end
      end
      if (out_valid_b && out_ready) begin
        if (qb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL out_b_unexpected: got result %0d, expected no result", $signed(out_data_b));
        end else begin
          e = qb.pop_front();
          check("out_data_b", longint'($signed(out_data_b)), e.data);
          check("sat_flag_b", longint'(sat_b), longint'(e.sat));
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    int n;
    int bad;
    longint held;
    rst_n = 1'b0; flush = 1'b0; wld_en = 1'b0; wld_idx = '0; wld_shift = '0;
    wld_neg = 1'b0; wld_zero = 1'b0; in_valid = 1'b0; in_data = '0;
    out_ready = 1'b1; rand_ready = 1'b0;
    model_reset();
    repeat (3) tick();
    check("rst_in_ready", longint'(in_ready_a), 1);
    check("rst_out_valid", longint'(out_valid_a), 0);
    check("rst_out_data", longint'(out_data_a), 0);
    check("rst_sat_flag", longint'(sat_a), 0);
    rst_n = 1'b1;
    tick();

    // Dot product with the reference weight set.
    write_w(0, 0, 1'b0, 1'b0);
    write_w(1, 1, 1'b0, 1'b0);
    write_w(2, 2, 1'b1, 1'b0);
    write_w(3, 3, 1'b0, 1'b0);
    write_w(4, 0, 1'b0, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      send(i, 1'b0, 0, 0, 1'b0, 1'b0);
      check("fill_in_ready", longint'(in_ready_a), 1);
    end
    send(5, 1'b0, 0, 0, 1'b0, 1'b0);
    wait_valid("dot_valid", n);
    check("dot_latency", n + 1, K + 1);
    check("dot_17", longint'($signed(out_data_a)), 17);
    tick();
    send(10, 1'b0, 0, 0, 1'b0, 1'b0);
    wait_valid("dot2_valid", n);
    check("dot_28", longint'($signed(out_data_a)), 28);
    tick();

    // Backpressure: result must hold and a stray in_valid must not be taken.
    out_ready = 1'b0;
    send(7, 1'b0, 0, 0, 1'b0, 1'b0);
    wait_valid("bp_valid", n);
    held = longint'($signed(out_data_a));
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (!out_valid_a || in_ready_a || longint'($signed(out_data_a)) != held) bad++;
      in_valid = (i == 5);
      in_data  = 8'd99;
      tick();
    end
    in_valid = 1'b0;
    check("bp_hold_cycles_bad", bad, 0);
    out_ready = 1'b1;
    tick();
    check("bp_release_ready", longint'(in_ready_a), 1);

    // Saturation: the 16-bit instance clamps, the 20-bit one does not.
    do_flush();
    for (int k = 0; k < K; k++) write_w(k, 7, 1'b0, 1'b0);
    for (int i = 0; i < K; i++) send(127, 1'b0, 0, 0, 1'b0, 1'b0);
    wait_valid("satp_valid", n);
    check("satp_data_b", longint'($signed(out_data_b)), 32767);
    check("satp_flag_b", longint'(sat_b), 1);
    check("satp_flag_a", longint'(sat_a), 0);
    tick();
    do_flush();
    check("flush_clears_sat", longint'(sat_b), 0);
    for (int i = 0; i < K; i++) send(-128, 1'b0, 0, 0, 1'b0, 1'b0);
    wait_valid("satn_valid", n);
    check("satn_data_b", longint'($signed(out_data_b)), -32768);
    tick();

    // Flush on the third ACC cycle aborts the result but keeps the weights.
    send(50, 1'b0, 0, 0, 1'b0, 1'b0);
    tick();
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    model_flush();
    check("abort_in_ready", longint'(in_ready_a), 1);
    check("abort_out_valid", longint'(out_valid_a), 0);
    bad = 0;
    repeat (K + 3) begin
      tick();
      if (out_valid_a) bad++;
    end
    check("abort_no_valid", bad, 0);
    for (int i = 0; i < K - 1; i++) begin
      send(i * 9 - 20, 1'b0, 0, 0, 1'b0, 1'b0);
      check("refill_in_ready", longint'(in_ready_a), 1);
    end
    send(33, 1'b0, 0, 0, 1'b0, 1'b0);
    wait_valid("refill_valid", n);
    tick();

    // Weight-load gating: same-cycle write used, writes in ACC/OUT and idx>=K ignored.
    out_ready = 1'b0;
    send(3, 1'b1, 0, 2, 1'b1, 1'b0);
    wld_en = 1'b1; wld_idx = 3'd1; wld_shift = 3'd0; wld_neg = 1'b0; wld_zero = 1'b1;
    wait_valid("gate_valid", n);
    tick();
    tick();
    wld_en = 1'b0;
    out_ready = 1'b1;
    tick();
    write_w(5, 0, 1'b0, 1'b1);
    write_w(7, 1, 1'b1, 1'b1);
    send(-20, 1'b0, 0, 0, 1'b0, 1'b0);
    wait_valid("gate2_valid", n);
    tick();
    drain();

    // Randomised traffic with random backpressure and weight reloads.
    rand_ready = 1'b1;
    for (int i = 0; i < 150; i++) begin
      int r;
      int d;
      r = int'($urandom_range(0, 3));
      d = int'($urandom_range(0, 255)) - 128;
      if (r == 0)
        write_w(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
      else
        send(d, ($urandom_range(0, 3) == 0), int'($urandom_range(0, 7)),
             int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
             ($urandom_range(0, 3) == 0));
    end
    drain();
    rand_ready = 1'b0;
    out_ready = 1'b1;
    tick();

    // Reset in the middle of ACC, then a run with power-up weights gives 0.
    send(11, 1'b0, 0, 0, 1'b0, 1'b0);
    tick();
    rst_n = 1'b0;
    #1;
    model_reset();
    check("midrst_out_valid", longint'(out_valid_a), 0);
    check("midrst_in_ready", longint'(in_ready_a), 1);
    check("midrst_out_data_a", longint'(out_data_a), 0);
    check("midrst_out_data_b", longint'(out_data_b), 0);
    check("midrst_sat_b", longint'(sat_b), 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    send(9, 1'b0, 0, 0, 1'b0, 1'b0);
    send(-7, 1'b0, 0, 0, 1'b0, 1'b0);
    send(3, 1'b0, 0, 0, 1'b0, 1'b0);
    send(100, 1'b0, 0, 0, 1'b0, 1'b0);
    send(-128, 1'b0, 0, 0, 1'b0, 1'b0);
    wait_valid("postrst_valid", n);
    check("postrst_zero", longint'($signed(out_data_a)), 0);
    tick();
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pe_bs_fir.md
# pe_bs_fir

Parametrised serial-MAC FIR processing element using log-quantised (power-of-two) weights, so every multiply is a barrel shift. Holds a K-sample input window and a K-entry weight file. For each accepted sample it computes y[n] = sum over k of w[k]*x[n-k] with a single shifter over K cycles, using saturating accumulation and a ready/valid output. It is the next generation of the team's shift-based PE: generic tap count and widths, true signed arithmetic, runtime weight loading, flow control, and an overflow flag.

## Interface
- DATA_W, 8, signed input sample width
- K, 5, number of taps (>=2)
- SHIFT_W, 3, weight shift-amount width (max shift 2^SHIFT_W-1)
- ACC_W, 20, signed accumulator/output width; must be >= DATA_W + 2^SHIFT_W - 1
- clk  in  1  clock
- rst_n  in  1  reset rst_n, asynchronous, active-low; clock clk
- flush  in  1  synchronous clear of datapath state (weights kept)
- wld_en  in  1  weight write strobe; honoured only in IDLE
- wld_idx  in  clog2(K)  tap index to write; values >= K ignored
- wld_shift  in  SHIFT_W  shift amount; |w| = 2^shift
- wld_neg  in  1  1 = negative weight
- wld_zero  in  1  1 = weight is zero (tap contributes 0)
- in_valid  in  1  sample valid
- in_ready  out  1  high in IDLE only
- in_data  in  DATA_W  signed sample
- out_valid  out  1  result valid, held until accepted
- out_ready  in  1  downstream accept
- out_data  out  ACC_W  signed saturated result
- sat_flag  out  1  sticky: some accumulation saturated since reset/flush

## Operation
- Window win[0..K-1] (win[0] newest); on accept (in_valid & in_ready): win[0]<=in_data, win[k]<=win[k-1].
- fill counter 0..K, saturates at K; it increments on each accept.
- Term k: 0 if zero[k]; otherwise sign-extend win[k] to ACC_W, shift left by shift[k], and negate if neg[k].
- Accumulation uses a saturating signed add. The result clamps to [-2^(ACC_W-1), 2^(ACC_W-1)-1]; any clamp sets sat_flag.
- FSM:
  - IDLE: in_ready=1. On accept, if fill after the accept equals K, go to ACC with acc<=0 and k<=0. Otherwise stay in IDLE.
  - ACC: each cycle acc<=sat(acc+term(k)) and k<=k+1. At k==K-1, out_data<=final sum, then go to OUT.
  - OUT: out_valid=1. When out_ready is high, go to IDLE.
- Weight writes: wld_en is ignored outside IDLE. In IDLE, a weight write and a sample accept in the same cycle both take effect, and the new weight is used by the ensuing ACC.
- flush (highest priority, any state): next state IDLE; window, fill, acc, k, out_valid and sat_flag are cleared; out_data is held; weights are retained.
- Reset: all window/acc/out_data set to 0, fill=0, state IDLE, out_valid=0, sat_flag=0, and all weights set to zero=1, neg=0, shift=0.

## Timing
- Reset values: in_ready=1, out_valid=0, out_data=0, sat_flag=0.
- Sample accepted at edge t (window full) -> ACC at cycles t+1..t+K -> out_valid high from t+K+1.
- in_ready is low from t+1 until the cycle after out_valid&out_ready.
- Max throughput: one sample per K+2 cycles with out_ready tied high.
- Backpressure: while out_ready is low, out_valid and out_data hold stable indefinitely and no sample is accepted.
- The first K-1 accepted samples after reset/flush produce no output, and in_ready stays 1 throughout.
- sat_flag rises on the edge that writes the saturated acc and stays high until flush or reset.
- flush asserted during ACC aborts the computation: no out_valid is produced, and in_ready is 1 on the next cycle.

## Test plan
- Reset: hold rst_n low mid-ACC -> out_valid=0, in_ready=1, out_data=0, sat_flag=0; a following run with no weights loaded gives out_data=0.
- Dot product (defaults): load w0=+1(s0), w1=+2(s1), w2=-4(s2,neg), w3=+8(s3), w4 zero; feed 1,2,3,4,5.
  - No output after samples 1-4.
  - After 5: out_data=17, out_valid exactly K+1 cycles after accept.
  - Then feed 10: out_data=28.
- Backpressure: hold out_ready=0 for 20 cycles after out_valid -> out_data stable, in_ready=0, and an in_valid pulse is not consumed; release -> IDLE next cycle.
- Saturation (ACC_W=16): all weights +2^7; feed 127 x5 -> out_data=32767, sat_flag=1; flush; feed -128 x5 -> out_data=-32768.
- Flush mid-ACC: flush on the third ACC cycle -> no out_valid, fill=0, and the next 4 samples give no output while weights are kept.
- Weight-load gating: wld_en during ACC/OUT is ignored; wld_idx=K is ignored; a write in the same cycle as the K-th accept is used in that result.
